// File: rtl/sw_pkg.sv
// Shared definitions for the Smith-Waterman array feeder and PE chain.
// Base encodings, score width and the feeder job-sequencing states.
package sw_pkg;

    localparam int unsigned BASE_W  = 2;
    localparam int unsigned SCORE_W = 10;

    typedef enum logic [1:0] {
        BASE_A = 2'd0,
        BASE_C = 2'd1,
        BASE_G = 2'd2,
        BASE_T = 2'd3
    } base_e;

    typedef enum logic [2:0] {
        IDLE,
        LOAD_Q,
        STREAM,
        FLUSH,
        DRAIN
    } sw_state_e;

endpackage

// File: rtl/sw_onehot_sel.sv
// Load-position counter with a registered one-hot strobe output.
// Each enabled cycle strobes the current position and advances it.
module sw_onehot_sel #(
    parameter int unsigned N = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_clr,
    input  logic         i_en,
    output logic [N-1:0] o_onehot,
    output logic         o_last
);

    localparam int unsigned CntW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CntW-1:0] LastPos = CntW'(N - 1);

    logic [CntW-1:0] r_pos;
    logic [N-1:0]    w_one;

    assign w_one  = N'(1);
    assign o_last = (r_pos == LastPos);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pos    <= '0;
            o_onehot <= '0;
        end else begin
            if (i_clr) begin
                r_pos <= '0;
            end else if (i_en) begin
                r_pos <= (r_pos == LastPos) ? '0 : r_pos + 1'b1;
            end
            o_onehot <= i_en ? (w_one << r_pos) : '0;
        end
    end

endmodule

// File: rtl/sw_array_feeder.sv
// Head-end driver for the Smith-Waterman systolic PE chain: loads the query
// into the PEs, streams the reference into PE 0 and sequences the job.
module sw_array_feeder
    import sw_pkg::*;
#(
    parameter int unsigned NUM_PE  = 16,
    parameter int unsigned SCORE_W = 10
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [1:0]         q_data,
    input  logic               q_valid,
    output logic               q_ready,
    input  logic [1:0]         r_data,
    input  logic               r_valid,
    input  logic               r_last,
    output logic               r_ready,
    output logic [1:0]         S_out,
    output logic [NUM_PE-1:0]  store_S,
    output logic [1:0]         T_out,
    output logic               init_out,
    output logic [SCORE_W-1:0] V_out,
    output logic [SCORE_W-1:0] F_out,
    output logic               busy,
    output logic               done,
    output logic               underrun
);

    localparam int unsigned DrainW = $clog2(NUM_PE + 1);
    localparam logic [DrainW-1:0] DrainLast = DrainW'(NUM_PE);

    sw_state_e         r_state;
    logic              r_started;
    logic [DrainW-1:0] r_drain_cnt;

    logic w_q_acc;
    logic w_r_acc;
    logic w_q_last;
    logic w_start;

    assign w_q_acc = q_valid & q_ready;
    assign w_r_acc = r_valid & r_ready;
    assign w_start = (r_state == IDLE) & start;

    // Local alignment: the left boundary of the matrix is always zero.
    assign V_out = '0;
    assign F_out = '0;

    sw_onehot_sel #(
        .N (NUM_PE)
    ) u_store_sel (
        .clk      (clk),
        .rst      (rst),
        .i_clr    (w_start),
        .i_en     (w_q_acc),
        .o_onehot (store_S),
        .o_last   (w_q_last)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_started   <= 1'b0;
            r_drain_cnt <= '0;
            q_ready     <= 1'b0;
            r_ready     <= 1'b0;
            S_out       <= '0;
            T_out       <= '0;
            init_out    <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            underrun    <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (r_state)
                IDLE: begin
                    if (start) begin
                        r_state  <= LOAD_Q;
                        q_ready  <= 1'b1;
                        busy     <= 1'b1;
                        underrun <= 1'b0;
                    end
                end
                LOAD_Q: begin
                    if (w_q_acc) begin
                        S_out <= q_data;
                        if (w_q_last) begin
                            r_state   <= STREAM;
                            q_ready   <= 1'b0;
                            r_ready   <= 1'b1;
                            r_started <= 1'b0;
                        end
                    end
                end
                STREAM: begin
                    if (w_r_acc) begin
                        T_out     <= r_data;
                        init_out  <= 1'b1;
                        r_started <= 1'b1;
                        if (r_last) begin
                            r_state     <= DRAIN;
                            r_ready     <= 1'b0;
                            r_drain_cnt <= '0;
                        end
                    end else if (r_started) begin
                        // The array cannot stall, so a missing beat poisons the job.
                        underrun <= 1'b1;
                        init_out <= 1'b0;
                        T_out    <= '0;
                        r_state  <= FLUSH;
                    end
                end
                FLUSH: begin
                    if (w_r_acc && r_last) begin
                        r_state     <= DRAIN;
                        r_ready     <= 1'b0;
                        r_drain_cnt <= '0;
                    end
                end
                DRAIN: begin
                    init_out <= 1'b0;
                    T_out    <= '0;
                    if (r_drain_cnt == DrainLast) begin
                        r_state <= IDLE;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                    end else begin
                        r_drain_cnt <= r_drain_cnt + 1'b1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sw_array_feeder.sv
// Directed bench for sw_array_feeder with NUM_PE = 4; every expected value
// below is hand-derived from the cycle-level behaviour of the feeder.
module tb_sw_array_feeder;

    localparam int unsigned NP = 4;
    localparam int unsigned SW = 10;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [1:0]    q_data;
    logic          q_valid;
    logic          q_ready;
    logic [1:0]    r_data;
    logic          r_valid;
    logic          r_last;
    logic          r_ready;
    logic [1:0]    S_out;
    logic [NP-1:0] store_S;
    logic [1:0]    T_out;
    logic          init_out;
    logic [SW-1:0] V_out;
    logic [SW-1:0] F_out;
    logic          busy;
    logic          done;
    logic          underrun;

    int n_vec  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    sw_array_feeder #(
        .NUM_PE  (NP),
        .SCORE_W (SW)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .q_data   (q_data),
        .q_valid  (q_valid),
        .q_ready  (q_ready),
        .r_data   (r_data),
        .r_valid  (r_valid),
        .r_last   (r_last),
        .r_ready  (r_ready),
        .S_out    (S_out),
        .store_S  (store_S),
        .T_out    (T_out),
        .init_out (init_out),
        .V_out    (V_out),
        .F_out    (F_out),
        .busy     (busy),
        .done     (done),
        .underrun (underrun)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Outputs are sampled 1 time unit after the active edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, ".store_S"}, 32'(store_S), 32'h0);
        chk({tag, ".S_out"}, 32'(S_out), 32'h0);
        chk({tag, ".T_out"}, 32'(T_out), 32'h0);
        chk({tag, ".init"}, 32'(init_out), 32'h0);
        chk({tag, ".q_ready"}, 32'(q_ready), 32'h0);
        chk({tag, ".r_ready"}, 32'(r_ready), 32'h0);
        chk({tag, ".busy"}, 32'(busy), 32'h0);
        chk({tag, ".done"}, 32'(done), 32'h0);
        chk({tag, ".underrun"}, 32'(underrun), 32'h0);
        chk({tag, ".VF"}, 32'({V_out, F_out}), 32'h0);
    endtask

    // Full back-to-back query load; state must be STREAM afterwards.
    task automatic load_query(input string tag, input logic [7:0] q);
        for (int i = 0; i < 4; i++) begin
            q_valid = 1'b1;
            q_data  = q[2*i +: 2];
            tick();
            chk($sformatf("%s.store%0d", tag, i), 32'(store_S), 32'(1) << i);
            chk($sformatf("%s.S%0d", tag, i), 32'(S_out), 32'(q[2*i +: 2]));
        end
        q_valid = 1'b0;
        chk({tag, ".q_ready_drop"}, 32'(q_ready), 32'h0);
        chk({tag, ".r_ready_rise"}, 32'(r_ready), 32'h1);
    endtask

    // DRAIN lasts NP+1 cycles after the last accept; done on the 5th tick.
    task automatic wait_done(input string tag, input logic exp_under);
        for (int k = 1; k <= 5; k++) begin
            tick();
            chk($sformatf("%s.done%0d", tag, k), 32'(done), (k == 5) ? 32'h1 : 32'h0);
            chk($sformatf("%s.busy%0d", tag, k), 32'(busy), (k == 5) ? 32'h0 : 32'h1);
            chk($sformatf("%s.init%0d", tag, k), 32'(init_out), 32'h0);
            chk($sformatf("%s.under%0d", tag, k), 32'(underrun), 32'(exp_under));
        end
        tick();
        chk({tag, ".done_pulse"}, 32'(done), 32'h0);
    endtask

    logic [1:0] ref6 [6];

    initial begin
        ref6[0] = 2'd2; ref6[1] = 2'd0; ref6[2] = 2'd3;
        ref6[3] = 2'd1; ref6[4] = 2'd1; ref6[5] = 2'd2;

        rst = 1'b1; start = 1'b0; q_data = '0; q_valid = 1'b0;
        r_data = '0; r_valid = 1'b0; r_last = 1'b0;
        tick();
        tick();
        chk_all_zero("reset");
        rst = 1'b0;

        // Job 1: query 0,1,2,3 then a 6-base reference.
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("j1.q_ready", 32'(q_ready), 32'h1);
        chk("j1.busy", 32'(busy), 32'h1);
        chk("j1.store_idle", 32'(store_S), 32'h0);
        load_query("j1", 8'b11_10_01_00);

        // Unbounded wait before the first beat; start is ignored here.
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        chk("j1.wait_init", 32'(init_out), 32'h0);
        chk("j1.wait_under", 32'(underrun), 32'h0);
        chk("j1.start_ign_q", 32'(q_ready), 32'h0);
        chk("j1.start_ign_r", 32'(r_ready), 32'h1);
        chk("j1.start_ign_s", 32'(store_S), 32'h0);

        for (int j = 0; j < 6; j++) begin
            r_valid = 1'b1;
            r_data  = ref6[j];
            r_last  = (j == 5);
            tick();
            chk($sformatf("j1.init%0d", j), 32'(init_out), 32'h1);
            chk($sformatf("j1.T%0d", j), 32'(T_out), 32'(ref6[j]));
        end
        r_valid = 1'b0;
        r_last  = 1'b0;
        chk("j1.r_ready_drain", 32'(r_ready), 32'h0);
        wait_done("j1", 1'b0);

        // Job 2: gapped query load, then an underrun after beat 3 of 6.
        start = 1'b1;
        tick();
        start = 1'b0;
        q_valid = 1'b1; q_data = 2'd3;
        tick();
        chk("j2.store0", 32'(store_S), 32'h1);
        chk("j2.S0", 32'(S_out), 32'h3);
        q_data = 2'd2;
        tick();
        chk("j2.store1", 32'(store_S), 32'h2);
        chk("j2.S1", 32'(S_out), 32'h2);
        q_valid = 1'b0;
        tick();
        chk("j2.gap0", 32'(store_S), 32'h0);
        tick();
        chk("j2.gap1", 32'(store_S), 32'h0);
        chk("j2.gap_ready", 32'(q_ready), 32'h1);
        q_valid = 1'b1; q_data = 2'd1;
        tick();
        chk("j2.store2", 32'(store_S), 32'h4);
        chk("j2.S2", 32'(S_out), 32'h1);
        q_data = 2'd0;
        tick();
        chk("j2.store3", 32'(store_S), 32'h8);
        chk("j2.S3", 32'(S_out), 32'h0);
        q_valid = 1'b0;
        tick();
        chk("j2.no_dup", 32'(store_S), 32'h0);
        chk("j2.q_ready_drop", 32'(q_ready), 32'h0);

        for (int j = 0; j < 3; j++) begin
            r_valid = 1'b1;
            r_data  = 2'(j + 1);
            tick();
            chk($sformatf("j2.init%0d", j), 32'(init_out), 32'h1);
            chk($sformatf("j2.T%0d", j), 32'(T_out), 32'(j + 1));
        end
        r_valid = 1'b0;
        tick();
        chk("j2.ur_init", 32'(init_out), 32'h0);
        chk("j2.ur_T", 32'(T_out), 32'h0);
        chk("j2.ur_flag", 32'(underrun), 32'h1);
        chk("j2.ur_r_ready", 32'(r_ready), 32'h1);
        for (int j = 3; j < 6; j++) begin
            r_valid = 1'b1;
            r_data  = 2'd3;
            r_last  = (j == 5);
            tick();
            chk($sformatf("j2.flush_init%0d", j), 32'(init_out), 32'h0);
            chk($sformatf("j2.flush_rdy%0d", j), 32'(r_ready), (j == 5) ? 32'h0 : 32'h1);
        end
        r_valid = 1'b0;
        r_last  = 1'b0;
        wait_done("j2", 1'b1);
        tick();
        chk("j2.under_sticky", 32'(underrun), 32'h1);

        // Job 3: reset in the middle of the query load.
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("j3.under_clr", 32'(underrun), 32'h0);
        q_valid = 1'b1; q_data = 2'd1;
        tick();
        q_data = 2'd2;
        tick();
        chk("j3.store1", 32'(store_S), 32'h2);
        q_valid = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk_all_zero("j3.rst");
        tick();
        chk("j3.idle_busy", 32'(busy), 32'h0);

        // Job 4: reload starts again from PE 0; single-base reference.
        start = 1'b1;
        tick();
        start = 1'b0;
        load_query("j4", 8'b01_00_11_10);
        r_valid = 1'b1; r_data = 2'd3; r_last = 1'b1;
        tick();
        r_valid = 1'b0; r_last = 1'b0;
        chk("j4.init", 32'(init_out), 32'h1);
        chk("j4.T", 32'(T_out), 32'h3);
        chk("j4.r_ready", 32'(r_ready), 32'h0);
        wait_done("j4", 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

// File: doc/sw_array_feeder.md
# sw_array_feeder

Head-end driver for the Smith-Waterman systolic PE chain. It loads one query base into each PE over a shared S bus with per-PE store strobes. It then streams the reference sequence into PE 0 as the T/init shift-in, holding the left-boundary score inputs at zero. It owns the job sequencing: idle, query load, stream, drain, done. It detects mid-stream underrun of the reference source, because the array has no stall capability.

## Interface
Parameters:
- NUM_PE, 16, number of PEs in the chain; query length is exactly NUM_PE.
- SCORE_W, 10, score width of the V/F boundary outputs.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset; synchronous, active-high.
- start  in  1  begin a job; sampled only in IDLE.
- q_data  in  2  query base.
- q_valid  in  1  query beat valid.
- q_ready  out  1  query beat accepted when q_valid & q_ready.
- r_data  in  2  reference base.
- r_valid  in  1  reference beat valid.
- r_last  in  1  marks the final reference beat.
- r_ready  out  1  reference beat accepted when r_valid & r_ready.
- S_out  out  2  query base broadcast to all PE S_in.
- store_S  out  NUM_PE  one-hot store strobe; bit i drives PE i.
- T_out  out  2  reference base to PE 0 T_in.
- init_out  out  1  computation-active flag to PE 0 init_in.
- V_out  out  SCORE_W  left-boundary score to PE 0 V_in; constant 0.
- F_out  out  SCORE_W  left-boundary gap score to PE 0 F_in; constant 0.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse at job end.
- underrun  out  1  sticky; cleared by the next accepted start.

## Operation
- All outputs are registered.
- Reset values: every output is 0, store_S = 0, state = IDLE, counters = 0.
- IDLE:
  - q_ready = 0 and r_ready = 0.
  - start moves to LOAD_Q and clears underrun.
  - start is ignored in every other state.
- LOAD_Q:
  - q_ready = 1.
  - Beat n (n = 0..NUM_PE-1) is written to S_out, with store_S = 1 << n, for exactly one cycle.
  - Gaps in q_valid are allowed; store_S = 0 during gaps.
  - After beat NUM_PE-1 is accepted, move to STREAM. q_ready drops the following cycle.
- STREAM:
  - r_ready = 1.
  - Each accepted beat produces T_out = r_data and init_out = 1 on the next cycle.
  - Before the first beat, waiting is unbounded and init_out stays 0.
  - After the first beat, every cycle must carry a beat.
  - Beat accepted with r_last: move to DRAIN.
  - r_valid = 0 after the first beat (underrun): set underrun, drive init_out = 0 and T_out = 0 next cycle, move to FLUSH.
  - r_last on the first beat is legal (single-base reference).
- FLUSH:
  - r_ready = 1 and init_out = 0.
  - Beats are discarded until a beat with r_last is accepted, then move to DRAIN.
- DRAIN:
  - r_ready = 0, init_out = 0, T_out = 0.
  - Lasts NUM_PE+1 cycles so the final wavefront exits the last PE.
  - Then pulse done for one cycle in the return transition to IDLE. busy falls the same cycle done rises.
- V_out and F_out are always 0 (local-alignment boundary).
- Reset mid-job: the next cycle is IDLE with reset outputs. Any partially loaded query is abandoned, and PEs keep whatever S values were stored.

## Timing
- Query load latency: accept at cycle k gives store_S/S_out at cycle k+1.
- Minimum load time: NUM_PE cycles.
- Stream latency: accept at k gives T_out/init_out at k+1.
- Throughput: one base per cycle.
- The init_out run length equals the number of reference beats, as long as no underrun occurs.
- LOAD_Q→STREAM: r_ready may rise in the cycle after the last q accept.
- Minimum job length from start, with always-valid sources: 1 + NUM_PE + R + NUM_PE + 1 cycles, plus the done cycle (R = reference length).

## Structure
- Shared package sw_pkg holds:
  - BASE_W = 2 and SCORE_W = 10.
  - Base encodings A/C/G/T = 0..3.
  - The state enum: IDLE, LOAD_Q, STREAM, FLUSH, DRAIN.
- The PE chain imports the same package.
- One sub-module, sw_onehot_sel:
  - Holds a load-position counter and produces a one-hot strobe with enable.
  - It is instantiated for store_S.
- The drain counter stays inline.

## Test plan
- NUM_PE=4, query 0,1,2,3 with always-valid sources → store_S = 0001,0010,0100,1000 on consecutive cycles, with S_out = 0,1,2,3.
- Query with a 2-cycle q_valid gap after beat 1 → store_S = 0 during the gap; the load completes with 4 strobes and no duplicates.
- Reference of 6 bases, r_last on beat 6 → init_out high exactly 6 cycles, T_out matches the bases; done pulses 4+1 cycles after the last init; busy falls with done.
- r_valid dropped after beat 3 of 6 → init_out low from the next cycle and underrun = 1; beats 4–6 are consumed with r_ready = 1; DRAIN then done; underrun holds until the next start.
- start asserted during STREAM → ignored. rst asserted mid-LOAD_Q → all outputs 0 next cycle, state IDLE; a new start reloads the query from PE 0.
- Single-base reference (r_last on first beat) → one init_out cycle, then DRAIN of NUM_PE+1 cycles and done.
